// File: rtl/alu_mdu.sv
// alu_mdu: RV32I base ALU plus RV32M multiply/divide behind one valid/ready handshake.
// Optional macro ALU_MDU_FAST_MUL_EN selects a single-cycle multiplier; divide stays iterative.
module alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_flush,
    input  logic            i_md_en,
    input  logic [3:0]      i_alu_op,
    input  logic [2:0]      i_md_op,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [XLEN-1:0] i_operand_b,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);
    localparam int              SW      = $clog2(XLEN);
    localparam logic [SW-1:0]   CNT_MAX = SW'(XLEN - 1);
    localparam logic [SW-1:0]   CNT_ONE = SW'(1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};

    localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b1000, OP_SLL = 4'b0001,
                           OP_SLT = 4'b0010, OP_SLTU = 4'b0011, OP_XOR = 4'b0100,
                           OP_SRL = 4'b0101, OP_SRA = 4'b1101, OP_OR = 4'b0110,
                           OP_AND = 4'b0111, OP_LUI = 4'b1111;
    localparam logic [2:0] MD_MUL = 3'b000, MD_MULH = 3'b001, MD_MULHSU = 3'b010,
                           MD_DIV = 3'b100, MD_REM = 3'b110;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_e;

    state_e              state_q, state_d;
    logic [SW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     a_mag_q, a_mag_d, b_mag_q, b_mag_d, a_raw_q, a_raw_d;
    logic [XLEN-1:0]     quo_q, quo_d, rem_q, rem_d, result_q, result_d;
    // Partial product never exceeds 2*XLEN-1 bits before the final step in FIX.
    logic [2*XLEN-2:0]   prod_q, prod_d;
    logic                neg_q, neg_d, div0_q, div0_d, ovf_q, ovf_d, valid_q, valid_d;

    logic [SW-1:0]       shamt_s;
    logic [XLEN-1:0]     alu_res_s, a_mag_s, b_mag_s;
    logic                a_neg_s, b_neg_s, neg_s;
    logic [2*XLEN-1:0]   prod_step_s, prod_fix_s;
    logic [XLEN:0]       rem_shift_s;
    logic [XLEN-1:0]     rem_step_s, quo_step_s, rem_fix_s, quo_fix_s, fix_res_s;
`ifdef ALU_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0]   fast_prod_s, fast_fix_s;
    logic [XLEN-1:0]     fast_res_s;
`endif

    assign shamt_s = i_operand_b[SW-1:0];

    // Single-cycle base ALU result
    always_comb begin
        alu_res_s = ZERO;
        case (i_alu_op)
            OP_ADD:  alu_res_s = i_operand_a + i_operand_b;
            OP_SUB:  alu_res_s = i_operand_a - i_operand_b;
            OP_SLL:  alu_res_s = i_operand_a << shamt_s;
            OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(i_operand_a) < $signed(i_operand_b))};
            OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (i_operand_a < i_operand_b)};
            OP_XOR:  alu_res_s = i_operand_a ^ i_operand_b;
            OP_SRL:  alu_res_s = i_operand_a >> shamt_s;
            OP_SRA:  alu_res_s = $unsigned($signed(i_operand_a) >>> shamt_s);
            OP_OR:   alu_res_s = i_operand_a | i_operand_b;
            OP_AND:  alu_res_s = i_operand_a & i_operand_b;
            OP_LUI:  alu_res_s = i_operand_b;
            default: alu_res_s = ZERO;
        endcase
    end

    // Operand signs, magnitudes and result sign captured at accept
    always_comb begin
        a_neg_s = ((i_md_op == MD_MULH) || (i_md_op == MD_MULHSU) || (i_md_op == MD_DIV) ||
                   (i_md_op == MD_REM)) && i_operand_a[XLEN-1];
        b_neg_s = ((i_md_op == MD_MULH) || (i_md_op == MD_DIV) || (i_md_op == MD_REM)) &&
                  i_operand_b[XLEN-1];
        a_mag_s = a_neg_s ? (ZERO - i_operand_a) : i_operand_a;
        b_mag_s = b_neg_s ? (ZERO - i_operand_b) : i_operand_b;
        // Remainder follows the dividend; everything else follows the sign product.
        neg_s   = (i_md_op == MD_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);
    end

`ifdef ALU_MDU_FAST_MUL_EN
    // Combinational multiplier on magnitudes
    always_comb begin
        fast_prod_s = {ZERO, a_mag_s} * {ZERO, b_mag_s};
        fast_fix_s  = neg_s ? ({(2*XLEN){1'b0}} - fast_prod_s) : fast_prod_s;
        fast_res_s  = (i_md_op == MD_MUL) ? fast_fix_s[XLEN-1:0] : fast_fix_s[2*XLEN-1:XLEN];
    end
`endif

    // One MSB-first iteration of shift-add multiply and restoring divide, indexed by cnt_q
    always_comb begin
        prod_step_s = {prod_q, 1'b0} +
                      (b_mag_q[cnt_q] ? {ZERO, a_mag_q} : {(2*XLEN){1'b0}});
        rem_shift_s = {rem_q, a_mag_q[cnt_q]};
        quo_step_s  = quo_q;
        if (rem_shift_s >= {1'b0, b_mag_q}) begin
            rem_step_s        = XLEN'(rem_shift_s - {1'b0, b_mag_q});
            quo_step_s[cnt_q] = 1'b1;
        end else begin
            rem_step_s        = rem_shift_s[XLEN-1:0];
        end
    end

    // Sign correction and forced special-case results applied in FIX
    always_comb begin
        prod_fix_s = neg_q ? ({(2*XLEN){1'b0}} - prod_step_s) : prod_step_s;
        if (div0_q) begin
            quo_fix_s = ALL_ONE;
            rem_fix_s = a_raw_q;
        end else if (ovf_q) begin
            quo_fix_s = a_raw_q;
            rem_fix_s = ZERO;
        end else begin
            quo_fix_s = neg_q ? (ZERO - quo_step_s) : quo_step_s;
            rem_fix_s = neg_q ? (ZERO - rem_step_s) : rem_step_s;
        end
        if (op_q[2]) begin
            fix_res_s = op_q[1] ? rem_fix_s : quo_fix_s;
        end else begin
            fix_res_s = (op_q == MD_MUL) ? prod_fix_s[XLEN-1:0] : prod_fix_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        a_raw_d  = a_raw_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        prod_d   = prod_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        valid_d  = 1'b0;
        if (i_flush) begin
            state_d = S_IDLE;
            cnt_d   = {SW{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!i_valid) begin
                        state_d = S_IDLE;
                    end else if (!i_md_en) begin
                        result_d = alu_res_s;
                        valid_d  = 1'b1;
`ifdef ALU_MDU_FAST_MUL_EN
                    end else if (!i_md_op[2]) begin
                        result_d = fast_res_s;
                        valid_d  = 1'b1;
`endif
                    end else begin
                        op_d    = i_md_op;
                        a_mag_d = a_mag_s;
                        b_mag_d = b_mag_s;
                        a_raw_d = i_operand_a;
                        neg_d   = neg_s;
                        div0_d  = (i_operand_b == ZERO);
                        ovf_d   = ((i_md_op == MD_DIV) || (i_md_op == MD_REM)) &&
                                  (i_operand_a == MIN_NEG) && (i_operand_b == ALL_ONE);
                        prod_d  = {(2*XLEN-1){1'b0}};
                        rem_d   = ZERO;
                        quo_d   = ZERO;
                        cnt_d   = CNT_MAX;
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    prod_d = prod_step_s[2*XLEN-2:0];
                    rem_d  = rem_step_s;
                    quo_d  = quo_step_s;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_CALC;
                    end
                end
                S_FIX: begin
                    result_d = fix_res_s;
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = {SW{1'b0}};
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {SW{1'b0}};
            op_q     <= 3'b000;
            a_mag_q  <= ZERO;
            b_mag_q  <= ZERO;
            a_raw_q  <= ZERO;
            quo_q    <= ZERO;
            rem_q    <= ZERO;
            prod_q   <= {(2*XLEN-1){1'b0}};
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= ZERO;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            a_raw_q  <= a_raw_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            prod_q   <= prod_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready  = (state_q == S_IDLE);
    assign o_busy   = (state_q != S_IDLE);
    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: directed vector table, multi-cycle sequences
// (back-to-back, flush, reset) and randomized ops against an arithmetic reference model.
module tb_alu_mdu;
    localparam int XLEN   = 32;
    localparam int MD_LAT = XLEN + 1;
`ifdef ALU_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic            i_flush = 1'b0;
    logic            i_md_en = 1'b0;
    logic [3:0]      i_alu_op = 4'd0;
    logic [2:0]      i_md_op = 3'd0;
    logic [XLEN-1:0] i_operand_a = '0;
    logic [XLEN-1:0] i_operand_b = '0;
    logic            o_valid;
    logic [XLEN-1:0] o_result;
    logic            o_busy;

    int n_pass = 0;
    int n_total = 0;

    alu_mdu #(.XLEN(XLEN)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_flush(i_flush), .i_md_en(i_md_en), .i_alu_op(i_alu_op), .i_md_op(i_md_op),
        .i_operand_a(i_operand_a), .i_operand_b(i_operand_b), .o_valid(o_valid),
        .o_result(o_result), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        bit         md;
        logic [3:0] aop;
        logic [2:0] mop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int         lat;
        string      name;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: RV32I/RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input bit md, input logic [3:0] aop,
                                              input logic [2:0] mop, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        logic [31:0] res;
        res = 32'd0;
        if (!md) begin
            sa = longint'($signed(a));
            case (aop)
                4'b0000: res = a + b;
                4'b1000: res = a - b;
                4'b0001: res = a << b[4:0];
                4'b0010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                4'b0011: res = (a < b) ? 32'd1 : 32'd0;
                4'b0100: res = a ^ b;
                4'b0101: res = a >> b[4:0];
                4'b1101: begin p = sa >>> b[4:0]; res = p[31:0]; end
                4'b0110: res = a | b;
                4'b0111: res = a & b;
                4'b1111: res = b;
                default: res = 32'd0;
            endcase
        end else begin
            sa = (mop == 3'd1 || mop == 3'd2 || mop == 3'd4 || mop == 3'd6) ?
                 longint'($signed(a)) : longint'({32'd0, a});
            sb = (mop == 3'd1 || mop == 3'd4 || mop == 3'd6) ?
                 longint'($signed(b)) : longint'({32'd0, b});
            if (!mop[2]) begin
                p = sa * sb;
                res = (mop == 3'd0) ? p[31:0] : p[63:32];
            end else if (b == 32'd0) begin
                res = mop[1] ? a : 32'hFFFFFFFF;
            end else if (!mop[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                res = mop[1] ? 32'd0 : a;
            end else begin
                p = mop[1] ? (sa % sb) : (sa / sb);
                res = p[31:0];
            end
        end
        return res;
    endfunction

    // Called at a negedge; returns at the negedge where o_valid is seen.
    task automatic run_op(input bit md, input logic [3:0] aop, input logic [2:0] mop,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        int guard = 0;
        while (!o_ready && guard < 200) begin
            @(negedge i_clk);
            guard++;
        end
        if (!o_ready) check("ready_timeout", {31'd0, o_ready}, 32'd1);
        i_valid = 1'b1; i_md_en = md; i_alu_op = aop; i_md_op = mop;
        i_operand_a = a; i_operand_b = b;
        @(posedge i_clk);
        lat = 0;
        do begin
            @(negedge i_clk);
            i_valid = 1'b0;
            i_operand_a = $urandom;
            i_operand_b = $urandom;
            lat++;
        end while (!o_valid && lat < 200);
        if (!o_valid) check("valid_timeout", {31'd0, o_valid}, 32'd1);
        res = o_result;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        vec_t vecs[$];
        logic [31:0] res, prev, exp;
        int lat, cnt, exp_lat;
        bit md;
        logic [3:0] aop;
        logic [2:0] mop;
        logic [31:0] a, b;

        vecs.push_back('{1'b0, 4'b1000, 3'd0, 32'd5, 32'd7, 32'hFFFFFFFE, 1, "SUB"});
        vecs.push_back('{1'b0, 4'b1101, 3'd0, 32'h80000000, 32'd4, 32'hF8000000, 1, "SRA"});
        vecs.push_back('{1'b0, 4'b0011, 3'd0, 32'd1, 32'hFFFFFFFF, 32'd1, 1, "SLTU"});
        vecs.push_back('{1'b0, 4'b0010, 3'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 1, "SLT"});
        vecs.push_back('{1'b0, 4'b0000, 3'd0, 32'd7, 32'd8, 32'd15, 1, "ADD"});
        vecs.push_back('{1'b0, 4'b0001, 3'd0, 32'd1, 32'h00000021, 32'd2, 1, "SLL_shamt"});
        vecs.push_back('{1'b0, 4'b0101, 3'd0, 32'h80000000, 32'd4, 32'h08000000, 1, "SRL"});
        vecs.push_back('{1'b0, 4'b0100, 3'd0, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1, "XOR"});
        vecs.push_back('{1'b0, 4'b1111, 3'd0, 32'd9, 32'h12345000, 32'h12345000, 1, "LUI"});
        vecs.push_back('{1'b0, 4'b1001, 3'd0, 32'd9, 32'd3, 32'd0, 1, "BADOP"});
        vecs.push_back('{1'b1, 4'd0, 3'b001, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, MUL_LAT, "MULH"});
        vecs.push_back('{1'b1, 4'd0, 3'b011, 32'hFFFFFFFF, 32'd2, 32'd1, MUL_LAT, "MULHU"});
        vecs.push_back('{1'b1, 4'd0, 3'b000, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFA, MUL_LAT, "MUL"});
        vecs.push_back('{1'b1, 4'd0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, "MULHSU"});
        vecs.push_back('{1'b1, 4'd0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, "MULH_min"});
        vecs.push_back('{1'b1, 4'd0, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, MD_LAT, "DIV"});
        vecs.push_back('{1'b1, 4'd0, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, MD_LAT, "REM"});
        vecs.push_back('{1'b1, 4'd0, 3'b101, 32'h80000000, 32'd0, 32'hFFFFFFFF, MD_LAT, "DIVU_0"});
        vecs.push_back('{1'b1, 4'd0, 3'b110, 32'd9, 32'd0, 32'd9, MD_LAT, "REM_0"});
        vecs.push_back('{1'b1, 4'd0, 3'b100, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, MD_LAT, "DIV_0"});
        vecs.push_back('{1'b1, 4'd0, 3'b110, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, MD_LAT, "REM_0neg"});
        vecs.push_back('{1'b1, 4'd0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, MD_LAT, "DIV_ovf"});
        vecs.push_back('{1'b1, 4'd0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, MD_LAT, "REM_ovf"});
        vecs.push_back('{1'b1, 4'd0, 3'b111, 32'd100, 32'd7, 32'd2, MD_LAT, "REMU"});

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].md, vecs[i].aop, vecs[i].mop, vecs[i].a, vecs[i].b, res, lat);
            check({vecs[i].name, "_res"}, res, vecs[i].exp);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
            @(negedge i_clk);
            check({vecs[i].name, "_pulse"}, {31'd0, o_valid}, 32'd0);
        end

        // Back-to-back: DIVU 100/7 then ADD 1+1 held until ready
        i_valid = 1'b1; i_md_en = 1'b1; i_md_op = 3'b101;
        i_operand_a = 32'd100; i_operand_b = 32'd7;
        @(posedge i_clk);
        @(negedge i_clk);
        check("b2b_busy", {31'd0, o_busy}, 32'd1);
        i_md_en = 1'b0; i_alu_op = 4'b0000; i_operand_a = 32'd1; i_operand_b = 32'd1;
        cnt = 0;
        while (!o_ready && cnt < 200) begin
            cnt++;
            @(negedge i_clk);
        end
        check("b2b_ready_low", 32'(cnt), 32'(XLEN));
        check("b2b_div_valid", {31'd0, o_valid}, 32'd1);
        check("b2b_div_res", o_result, 32'd14);
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        check("b2b_add_valid", {31'd0, o_valid}, 32'd1);
        check("b2b_add_res", o_result, 32'd2);

        // Flush at CALC cycle 10 of a DIV, with a competing request that must be dropped
        @(negedge i_clk);
        prev = o_result;
        i_valid = 1'b1; i_md_en = 1'b1; i_md_op = 3'b100;
        i_operand_a = 32'hFFFFFF9C; i_operand_b = 32'd3;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (9) @(negedge i_clk);
        i_flush = 1'b1; i_valid = 1'b1; i_md_en = 1'b0; i_alu_op = 4'b0000;
        i_operand_a = 32'd3; i_operand_b = 32'd4;
        @(negedge i_clk);
        i_flush = 1'b0; i_valid = 1'b0;
        check("flush_ready", {31'd0, o_ready}, 32'd1);
        check("flush_busy", {31'd0, o_busy}, 32'd0);
        check("flush_valid", {31'd0, o_valid}, 32'd0);
        check("flush_result", o_result, prev);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (o_valid) cnt++;
        end
        check("flush_no_valid", 32'(cnt), 32'd0);
        check("flush_result_hold", o_result, prev);

        // Reset at CALC cycle 10, asserted together with flush
        i_valid = 1'b1; i_md_en = 1'b1; i_md_op = 3'b100;
        i_operand_a = 32'd1000; i_operand_b = 32'd3;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (9) @(negedge i_clk);
        i_reset = 1'b1; i_flush = 1'b1;
        @(negedge i_clk);
        check("mrst_valid", {31'd0, o_valid}, 32'd0);
        check("mrst_result", o_result, 32'd0);
        check("mrst_busy", {31'd0, o_busy}, 32'd0);
        check("mrst_ready", {31'd0, o_ready}, 32'd1);
        i_reset = 1'b0; i_flush = 1'b0;
        @(negedge i_clk);
        check("mrst_after_valid", {31'd0, o_valid}, 32'd0);

        // Randomized ops against the reference model
        for (int n = 0; n < 200; n++) begin
            md  = 1'($urandom_range(0, 1));
            aop = 4'($urandom_range(0, 15));
            mop = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            exp = ref_model(md, aop, mop, a, b);
            exp_lat = !md ? 1 : (mop[2] ? MD_LAT : MUL_LAT);
            run_op(md, aop, mop, a, b, res, lat);
            check($sformatf("rnd%0d_res md=%0d aop=%0h mop=%0d a=%h b=%h", n, md, aop, mop, a, b),
                  res, exp);
            check($sformatf("rnd%0d_lat", n), 32'(lat), 32'(exp_lat));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
